dot_product_accumulator: RTL

//   Downstream stage of the 32x32 Vedic multiplier in the matrix-multiply datapath.

---
 rtl/mm_pkg.sv | 18 +
 rtl/result_fifo2.sv | 45 ++++
 rtl/dot_product_accumulator.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply datapath: product width,
// default pipeline geometry and the finished-element record.
package mm_pkg;

    localparam int unsigned PROD_W          = 64;
    localparam int unsigned DEF_MUL_LATENCY = 6;
    localparam int unsigned DEF_MAX_LEN     = 16;
    localparam int unsigned DEF_CNT_W       = $clog2(DEF_MAX_LEN + 1);
    localparam int unsigned DEF_ACC_W       = PROD_W + DEF_CNT_W;

    // Result record at the default geometry; modules with other widths declare their own.
    typedef struct packed {
        logic [DEF_ACC_W-1:0] sum;
        logic [DEF_CNT_W-1:0] count;
        logic                 err;
    } result_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry first-word-fall-through FIFO; head is valid whenever empty is low.
module result_fifo2 #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count,
    output logic         empty,
    output logic         full
);

    logic [W-1:0] mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic         do_pop;

    assign empty  = (count == 2'd0);
    assign full   = (count == 2'd2);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/dot_product_accumulator.sv
// Sums the multiplier's product stream into matrix elements, realigning issue
// tokens to the multiplier latency and buffering results in a 2-entry FIFO.
module dot_product_accumulator
    import mm_pkg::*;
#(
    parameter  int unsigned MUL_LATENCY = DEF_MUL_LATENCY,
    parameter  int unsigned MAX_LEN     = DEF_MAX_LEN,
    localparam int unsigned CNT_W       = $clog2(MAX_LEN + 1),
    localparam int unsigned ACC_W       = PROD_W + CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              len_err
);

    localparam int unsigned LW = $clog2(MUL_LATENCY + 3);

    typedef struct packed {
        logic [ACC_W-1:0] sum;
        logic [CNT_W-1:0] count;
        logic             err;
    } rec_t;

    logic [MUL_LATENCY-1:0] line_valid;
    logic [MUL_LATENCY-1:0] line_last;
    logic [MUL_LATENCY-1:0] line_close;
    logic [CNT_W-1:0]       issue_cnt;
    logic                   issue_fire;
    logic                   issue_close;
    logic                   d_valid;
    logic                   d_last;
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       acc_next;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_next;
    logic                   first;
    logic                   close;
    logic [LW-1:0]          closing;
    logic [LW-1:0]          credit;
    logic [1:0]             fifo_count;
    logic                   fifo_empty;
    logic                   fifo_full;
    rec_t                   push_rec;
    rec_t                   head_rec;

    assign issue_fire  = in_valid && in_ready;
    // Issue-side beat count predicts which tokens will close an element, so the
    // FIFO credit check can see forced closes while they are still in flight.
    assign issue_close = in_last || (issue_cnt == CNT_W'(MAX_LEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_valid <= '0;
            line_last  <= '0;
            line_close <= '0;
            issue_cnt  <= '0;
        end else begin
            line_valid[0] <= issue_fire;
            line_last[0]  <= in_last;
            line_close[0] <= issue_close;
            for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
                line_valid[i] <= line_valid[i-1];
                line_last[i]  <= line_last[i-1];
                line_close[i] <= line_close[i-1];
            end
            if (issue_fire) begin
                issue_cnt <= issue_close ? '0 : issue_cnt + CNT_W'(1);
            end
        end
    end

    assign d_valid = line_valid[MUL_LATENCY-1];
    assign d_last  = line_last[MUL_LATENCY-1];

    always_comb begin
        closing = '0;
        for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
            if (line_valid[i] && line_close[i]) begin
                closing = closing + LW'(1);
            end
        end
        credit = LW'(2) - LW'(fifo_count);
    end

    assign in_ready = (credit > closing);

    always_comb begin
        acc_next = (first ? '0 : acc) + ACC_W'(product);
        cnt_next = first ? CNT_W'(1) : cnt + CNT_W'(1);
        close    = d_valid && (d_last || (cnt_next == CNT_W'(MAX_LEN)));
        push_rec = '{sum: acc_next, count: cnt_next, err: !d_last};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            first <= 1'b1;
        end else if (d_valid) begin
            acc   <= acc_next;
            cnt   <= cnt_next;
            first <= close;
        end
    end

    result_fifo2 #(
        .W($bits(rec_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (close),
        .push_data (push_rec),
        .pop       (out_valid && out_ready),
        .head      (head_rec),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign out_valid = !fifo_empty;
    assign out_sum   = head_rec.sum;
    assign out_count = head_rec.count;
    assign len_err   = head_rec.err;

    no_push_when_full: assert property (@(posedge clk) disable iff (rst) !(close && fifo_full));

endmodule
